bram_loader: RTL

- Initiator/writer for the single-port 8-bit boot BRAM (en/we/addr/din/dout port, one-cycle registered read).
- Accepts a byte stream from the boot-image source (SD/UART front end) over a valid/ready handshake and writes LEN bytes sequentially from address 0.
- Then reads the image back to verify an 8-bit checksum and captures the machine-signature byte at address 0 (0x38 = Tandy).
- Holds the CPU in reset until a verified image is present.

---
 rtl/bram_loader_if.sv | 24 ++
 rtl/bram_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bram_loader_if.sv
// Stream-in and BRAM-port signal bundle for the boot-image loader.
// The master side is the loader; the slave side is the stream source plus the BRAM.
interface bram_loader_if #(
    parameter int AW = 16
) ();
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic [7:0]    bram_dout;

    modport master (
        input  s_data, s_valid, bram_dout,
        output s_ready, bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        output s_data, s_valid, bram_dout,
        input  s_ready, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_loader.sv
// Boot BRAM loader: streams LEN bytes into the BRAM, reads them back to verify an
// 8-bit checksum, captures the machine-signature byte and gates the CPU reset.
module bram_loader #(
    parameter int AW  = 16,
    parameter int LEN = 65536
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    bram_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         is_tandy,
    output logic         cpu_hold
);
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic [7:0]    wsum_reg, wsum_next;
    logic [7:0]    rsum_reg, rsum_next;
    logic          rd_pend_reg, rd_pend_next;
    logic          rd0_reg, rd0_next;
    logic          error_reg, error_next;
    logic          tandy_reg, tandy_next;
    logic [7:0]    rsum_plus;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wsum_reg    <= '0;
            rsum_reg    <= '0;
            rd_pend_reg <= 1'b0;
            rd0_reg     <= 1'b0;
            error_reg   <= 1'b0;
            tandy_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wsum_reg    <= wsum_next;
            rsum_reg    <= rsum_next;
            rd_pend_reg <= rd_pend_next;
            rd0_reg     <= rd0_next;
            error_reg   <= error_next;
            tandy_reg   <= tandy_next;
        end
    end

    assign rsum_plus = rsum_reg + bus.bram_dout;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        wsum_next     = wsum_reg;
        rsum_next     = rsum_reg;
        rd_pend_next  = 1'b0;
        rd0_next      = 1'b0;
        error_next    = error_reg;
        tandy_next    = tandy_reg;
        bus.s_ready   = 1'b0;
        bus.bram_en   = 1'b0;
        bus.bram_we   = 1'b0;
        bus.bram_addr = '0;
        bus.bram_din  = '0;

        // Data for the address-0 read lands one cycle later, in VERIFY or (LEN=1) CHECK.
        if (rd0_reg) begin
            tandy_next = (bus.bram_dout == 8'h38);
        end

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    wsum_next  = '0;
                    rsum_next  = '0;
                    error_next = 1'b0;
                    tandy_next = 1'b0;
                end
            end
            LOAD: begin
                bus.s_ready   = 1'b1;
                bus.bram_en   = bus.s_valid;
                bus.bram_we   = bus.s_valid;
                bus.bram_addr = cnt_reg;
                bus.bram_din  = bus.s_data;
                if (bus.s_valid) begin
                    wsum_next = wsum_reg + bus.s_data;
                    if (cnt_reg == LAST_ADDR) begin
                        state_next = VERIFY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            VERIFY: begin
                bus.bram_en   = 1'b1;
                bus.bram_addr = cnt_reg;
                rd_pend_next  = 1'b1;
                rd0_next      = (cnt_reg == '0);
                cnt_next      = cnt_reg + 1'b1;
                if (rd_pend_reg) begin
                    rsum_next = rsum_plus;
                end
                if (cnt_reg == LAST_ADDR) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                // The last read's data is folded in here; it never reaches rsum_reg first.
                rsum_next  = rsum_plus;
                error_next = (rsum_plus != wsum_reg);
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg == LOAD) || (state_reg == VERIFY) || (state_reg == CHECK);
    assign done     = (state_reg == DONE);
    assign error    = error_reg;
    assign is_tandy = tandy_reg;
    assign cpu_hold = !((state_reg == DONE) && !error_reg);
endmodule
